// File: rtl/axi4_lite_master_if.sv
// rtl/axi4_lite_master_if.sv - AXI4-Lite bus bundle between the initiator and a slave
interface axi4_lite_master_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0]  M_AXI_AWADDR;
  logic                      M_AXI_AWVALID;
  logic                      M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]     M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB;
  logic                      M_AXI_WVALID;
  logic                      M_AXI_WREADY;
  logic [1:0]                M_AXI_BRESP;
  logic                      M_AXI_BVALID;
  logic                      M_AXI_BREADY;
  logic [ADDRESS_WIDTH-1:0]  M_AXI_ARADDR;
  logic                      M_AXI_ARVALID;
  logic                      M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]     M_AXI_RDATA;
  logic [1:0]                M_AXI_RRESP;
  logic                      M_AXI_RVALID;
  logic                      M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - single-outstanding AXI4-Lite initiator driven by a local command port
module axi4_lite_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  axi4_lite_master_if.master        m_axi
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;

  assign aw_hs = m_axi.M_AXI_AWVALID && m_axi.M_AXI_AWREADY;
  assign w_hs  = m_axi.M_AXI_WVALID && m_axi.M_AXI_WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state               <= IDLE;
      aw_done             <= 1'b0;
      w_done              <= 1'b0;
      cmd_ready           <= 1'b1;
      rsp_valid           <= 1'b0;
      rsp_rdata           <= '0;
      rsp_resp            <= '0;
      m_axi.M_AXI_AWADDR  <= '0;
      m_axi.M_AXI_AWVALID <= 1'b0;
      m_axi.M_AXI_WDATA   <= '0;
      m_axi.M_AXI_WSTRB   <= '0;
      m_axi.M_AXI_WVALID  <= 1'b0;
      m_axi.M_AXI_BREADY  <= 1'b0;
      m_axi.M_AXI_ARADDR  <= '0;
      m_axi.M_AXI_ARVALID <= 1'b0;
      m_axi.M_AXI_RREADY  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axi.M_AXI_AWADDR  <= cmd_addr;
              m_axi.M_AXI_WDATA   <= cmd_wdata;
              m_axi.M_AXI_WSTRB   <= cmd_wstrb;
              m_axi.M_AXI_AWVALID <= 1'b1;
              m_axi.M_AXI_WVALID  <= 1'b1;
              aw_done             <= 1'b0;
              w_done              <= 1'b0;
              state               <= WRITE;
            end else begin
              m_axi.M_AXI_ARADDR  <= cmd_addr;
              m_axi.M_AXI_ARVALID <= 1'b1;
              state               <= RADDR;
            end
          end
        end
        WRITE: begin
          // AW and W complete independently; B is only opened once both are done
          if (aw_hs) begin
            m_axi.M_AXI_AWVALID <= 1'b0;
            aw_done             <= 1'b1;
          end
          if (w_hs) begin
            m_axi.M_AXI_WVALID <= 1'b0;
            w_done             <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_axi.M_AXI_BREADY <= 1'b1;
            aw_done            <= 1'b0;
            w_done             <= 1'b0;
            state              <= WRESP;
          end
        end
        WRESP: begin
          if (m_axi.M_AXI_BVALID) begin
            m_axi.M_AXI_BREADY <= 1'b0;
            rsp_valid          <= 1'b1;
            rsp_resp           <= m_axi.M_AXI_BRESP;
            rsp_rdata          <= '0;
            cmd_ready          <= 1'b1;
            state              <= IDLE;
          end
        end
        RADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            m_axi.M_AXI_ARVALID <= 1'b0;
            m_axi.M_AXI_RREADY  <= 1'b1;
            state               <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi.M_AXI_RVALID) begin
            m_axi.M_AXI_RREADY <= 1'b0;
            rsp_valid          <= 1'b1;
            rsp_resp           <= m_axi.M_AXI_RRESP;
            rsp_rdata          <= m_axi.M_AXI_RDATA;
            cmd_ready          <= 1'b1;
            state              <= IDLE;
          end
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - scoreboard bench for axi4_lite_master with a delay-programmable slave
module tb_axi4_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  axi4_lite_master_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_master #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .m_axi     (bus)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: word memory plus the queue of responses the DUT owes us
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] ref_mem[16];
  logic [31:0] slave_mem[16];

  int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
      e.rdata = 32'h0;
      e.resp  = bresp_cfg;
    end else begin
      e.rdata = ref_mem[a[5:2]];
      e.resp  = rresp_cfg;
    end
    exp_q.push_back(e);
  endtask

  // Slave: decisions made on the falling edge, so a handshake decided here happens at the next rising edge
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit          aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_ARREADY = 1'b0;
      bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = 2'b00;
      bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RRESP = 2'b00; bus.M_AXI_RDATA = '0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
    end else begin
      if (b_fire) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) slave_mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
        bus.M_AXI_BVALID = 1'b0; b_fire = 0; aw_got = 0; w_got = 0; b_cnt = 0;
      end else if (aw_got && w_got && !bus.M_AXI_BVALID) begin
        if (b_cnt >= b_dly) begin bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = bresp_cfg; end
        else b_cnt++;
      end
      b_fire = bus.M_AXI_BVALID && bus.M_AXI_BREADY;

      if (bus.M_AXI_AWVALID && !aw_got) begin
        if (aw_cnt >= aw_dly) begin
          bus.M_AXI_AWREADY = 1'b1; s_awaddr = bus.M_AXI_AWADDR; aw_got = 1;
        end else begin
          bus.M_AXI_AWREADY = 1'b0; aw_cnt++;
        end
      end else begin
        bus.M_AXI_AWREADY = 1'b0; aw_cnt = 0;
      end

      if (bus.M_AXI_WVALID && !w_got) begin
        if (w_cnt >= w_dly) begin
          bus.M_AXI_WREADY = 1'b1; s_wdata = bus.M_AXI_WDATA; s_wstrb = bus.M_AXI_WSTRB; w_got = 1;
        end else begin
          bus.M_AXI_WREADY = 1'b0; w_cnt++;
        end
      end else begin
        bus.M_AXI_WREADY = 1'b0; w_cnt = 0;
      end

      if (r_fire) begin
        bus.M_AXI_RVALID = 1'b0; r_fire = 0; ar_got = 0; r_cnt = 0;
      end else if (ar_got && !bus.M_AXI_RVALID) begin
        if (r_cnt >= r_dly) begin
          bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = slave_mem[s_araddr[5:2]]; bus.M_AXI_RRESP = rresp_cfg;
        end else r_cnt++;
      end
      r_fire = bus.M_AXI_RVALID && bus.M_AXI_RREADY;

      if (bus.M_AXI_ARVALID && !ar_got) begin
        if (ar_cnt >= ar_dly) begin
          bus.M_AXI_ARREADY = 1'b1; s_araddr = bus.M_AXI_ARADDR; ar_got = 1;
        end else begin
          bus.M_AXI_ARREADY = 1'b0; ar_cnt++;
        end
      end else begin
        bus.M_AXI_ARREADY = 1'b0; ar_cnt = 0;
      end
    end
  end

  // Scoreboard monitor
  int rsp_cnt = 0;
  always @(negedge ACLK) begin
    if (rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_resp", rsp_resp, e.resp);
      end
    end
  end

  // Protocol monitor: a VALID not yet accepted must persist with stable payload
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;
  always begin
    @(negedge ACLK);
    #1;
    if (!ARESETN) begin
      p_awv = 0; p_wv = 0; p_arv = 0;
    end else begin
      if (p_awv && !p_awr) check("aw_hold", {bus.M_AXI_AWVALID, bus.M_AXI_AWADDR}, {1'b1, p_awaddr});
      if (p_wv && !p_wr)   check("w_hold", {bus.M_AXI_WVALID, bus.M_AXI_WSTRB, bus.M_AXI_WDATA}, {1'b1, p_wstrb, p_wdata});
      if (p_arv && !p_arr) check("ar_hold", {bus.M_AXI_ARVALID, bus.M_AXI_ARADDR}, {1'b1, p_araddr});
      p_awv = bus.M_AXI_AWVALID; p_awr = bus.M_AXI_AWREADY; p_awaddr = bus.M_AXI_AWADDR;
      p_wv = bus.M_AXI_WVALID; p_wr = bus.M_AXI_WREADY; p_wdata = bus.M_AXI_WDATA; p_wstrb = bus.M_AXI_WSTRB;
      p_arv = bus.M_AXI_ARVALID; p_arr = bus.M_AXI_ARREADY; p_araddr = bus.M_AXI_ARADDR;
    end
  end

  // Returns at the falling edge after the acceptance edge; acc is the acceptance edge index
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output int acc);
    int t;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    t = 0;
    while (!cmd_ready && t < 200) begin @(negedge ACLK); t++; end
    if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
    acc = cyc + 1;
    model(w, a, d, s);
    @(negedge ACLK);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
  endtask

  task automatic wait_rsp(input int start);
    int t;
    t = 0;
    while (rsp_cnt == start && t < 100) begin @(negedge ACLK); t++; end
    if (rsp_cnt == start) check("rsp_timeout", 0, 1);
  endtask

  task automatic set_slave(input int awd, input int wd, input int bd, input int ard, input int rd,
                           input logic [1:0] br, input logic [1:0] rr);
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd; bresp_cfg = br; rresp_cfg = rr;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc, t, n_hi, start;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = 32'h0; slave_mem[i] = 32'h0; end
    ref_mem[1] = 32'h1234_5678; slave_mem[1] = 32'h1234_5678;

    repeat (3) @(negedge ACLK);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_ctl", {rsp_valid, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                        bus.M_AXI_ARVALID, bus.M_AXI_RREADY, rsp_resp}, 0);
    check("reset_rdata", rsp_rdata, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Zero-wait write: AW/W at N+1, B at N+2, rsp at N+3
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
    start = rsp_cnt;
    issue(1, 32'h10, 32'hDEAD_BEEF, 4'hF, acc);
    check("t1_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID}, 2'b11);
    check("t1_payload", {bus.M_AXI_AWADDR, bus.M_AXI_WDATA}, {32'h10, 32'hDEAD_BEEF});
    check("t1_wstrb", bus.M_AXI_WSTRB, 4'hF);
    @(negedge ACLK);
    check("t1_bready", {bus.M_AXI_BREADY, bus.M_AXI_AWVALID, bus.M_AXI_WVALID}, 3'b100);
    @(negedge ACLK);
    check("t1_rsp_at_n3", {rsp_valid, 32'(cyc + 1 - acc)}, {1'b1, 32'd3});
    wait_rsp(start);

    // Delayed read: ARVALID held for 4 cycles (ready on the 4th)
    set_slave(0, 0, 0, 3, 2, 2'b00, 2'b00);
    start = rsp_cnt;
    issue(0, 32'h04, 32'h0, 4'h0, acc);
    n_hi = 0; t = 0;
    while (bus.M_AXI_ARVALID && t < 20) begin
      check("t2_araddr", bus.M_AXI_ARADDR, 32'h04);
      n_hi++; @(negedge ACLK); t++;
    end
    check("t2_arvalid_len", n_hi, 4);
    wait_rsp(start);

    // W accepted at N+1, AW at N+4
    set_slave(3, 0, 0, 0, 0, 2'b00, 2'b00);
    start = rsp_cnt;
    issue(1, 32'h08, 32'h0BAD_F00D, 4'h5, acc);
    for (int k = 1; k <= 5; k++) begin
      check("t3_wvalid", bus.M_AXI_WVALID, (k == 1));
      check("t3_awvalid", bus.M_AXI_AWVALID, (k <= 4));
      check("t3_bready", bus.M_AXI_BREADY, (k == 5));
      @(negedge ACLK);
    end
    wait_rsp(start);

    // Error responses pass through
    set_slave(1, 2, 1, 0, 0, 2'b10, 2'b11);
    start = rsp_cnt;
    issue(1, 32'h30, 32'hCAFE_0001, 4'hC, acc);
    wait_rsp(start);
    start = rsp_cnt;
    issue(0, 32'h10, 32'h0, 4'h0, acc);
    wait_rsp(start);

    // Command held during a transaction is ignored until the completion cycle
    set_slave(2, 1, 2, 0, 0, 2'b00, 2'b00);
    start = rsp_cnt;
    issue(1, 32'h20, 32'hA5A5_0001, 4'hF, acc);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h24; cmd_wdata = 32'h5A5A_0002; cmd_wstrb = 4'h3;
    t = 0;
    while (!rsp_valid && t < 50) begin
      check("t5_busy_ready", cmd_ready, 0);
      if (bus.M_AXI_AWVALID) check("t5_awaddr", bus.M_AXI_AWADDR, 32'h20);
      if (bus.M_AXI_WVALID)  check("t5_wdata", bus.M_AXI_WDATA, 32'hA5A5_0001);
      @(negedge ACLK); t++;
    end
    check("t5_b2b_ready", {rsp_valid, cmd_ready}, 2'b11);
    issue(1, 32'h24, 32'h5A5A_0002, 4'h3, acc);
    wait_rsp(start + 1);

    // Reset during RDATA abandons the read
    set_slave(0, 0, 0, 0, 6, 2'b00, 2'b00);
    start = rsp_cnt;
    issue(0, 32'h20, 32'h0, 4'h0, acc);
    t = 0;
    while (!bus.M_AXI_RREADY && t < 20) begin @(negedge ACLK); t++; end
    check("t6_in_rdata", bus.M_AXI_RREADY, 1);
    ARESETN = 1'b0;
    #1;
    check("t6_axi_ctl", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                         bus.M_AXI_ARVALID, bus.M_AXI_RREADY, rsp_valid}, 0);
    check("t6_axi_addr", {bus.M_AXI_ARADDR, bus.M_AXI_AWADDR}, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    exp_q.delete();
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (4) @(negedge ACLK);
    check("t6_no_rsp", rsp_cnt, start);
    set_slave(0, 0, 0, 1, 1, 2'b00, 2'b00);
    start = rsp_cnt;
    issue(0, 32'h24, 32'h0, 4'h0, acc);
    wait_rsp(start);

    // Randomized traffic, including back-to-back commands
    for (int n = 0; n < 60; n++) begin
      bit          w;
      logic [31:0] a;
      t = 0;
      while (!cmd_ready && t < 100) begin @(negedge ACLK); t++; end
      set_slave(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      w = 1'($urandom_range(0, 1));
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      issue(w, a, $urandom, 4'($urandom), acc);
      repeat ($urandom_range(0, 2)) @(negedge ACLK);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge ACLK); t++; end
    check("drain", exp_q.size(), 0);
    repeat (3) @(negedge ACLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
